// File: rtl/fma16_result_stage.sv
// Output register stage for fma16 results: 2-entry skid buffer behind a valid/ready
// handshake, sticky {nv,of,uf,nx} accumulation and a retired-operation counter.
module fma16_result_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_result,
    input  logic [3:0]       in_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_result,
    output logic [3:0]       out_flags,
    input  logic             fflags_we,
    input  logic [3:0]       fflags_wdata,
    output logic [3:0]       fflags,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [15:0]        head_res_q, head_res_d;
    logic [3:0]         head_flg_q, head_flg_d;
    logic [15:0]        skid_res_q, skid_res_d;
    logic [3:0]         skid_flg_q, skid_flg_d;
    logic               out_valid_q;
    logic               in_ready_q;
    logic [3:0]         fflags_q, fflags_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept_s;
    logic               retire_s;

    // Next-state for the skid FSM, sticky flags and retire counter.
    always_comb begin
        accept_s   = in_valid & in_ready_q;
        retire_s   = out_valid_q & out_ready;
        state_d    = state_q;
        head_res_d = head_res_q;
        head_flg_d = head_flg_q;
        skid_res_d = skid_res_q;
        skid_flg_d = skid_flg_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept_s) begin
                    head_res_d = in_result;
                    head_flg_d = in_flags;
                    state_d    = ST_ONE;
                end else begin
                    state_d    = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (accept_s && retire_s) begin
                    head_res_d = in_result;
                    head_flg_d = in_flags;
                end else if (accept_s) begin
                    skid_res_d = in_result;
                    skid_flg_d = in_flags;
                    state_d    = ST_FULL;
                end else if (retire_s) begin
                    state_d    = ST_EMPTY;
                end else begin
                    state_d    = ST_ONE;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so the only event is draining the head.
                if (retire_s) begin
                    head_res_d = skid_res_q;
                    head_flg_d = skid_flg_q;
                    state_d    = ST_ONE;
                end else begin
                    state_d    = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        // Retiring flags are OR'd on top of a software write so none are lost.
        fflags_d = (fflags_we ? fflags_wdata : fflags_q) | (retire_s ? head_flg_q : 4'b0000);
        cnt_d    = cnt_q + {{(CNT_W-1){1'b0}}, retire_s};
    end

    // State and output registers; handshake outputs are decoded from next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            head_res_q  <= 16'h0000;
            head_flg_q  <= 4'b0000;
            skid_res_q  <= 16'h0000;
            skid_flg_q  <= 4'b0000;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            fflags_q    <= 4'b0000;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            head_res_q  <= head_res_d;
            head_flg_q  <= head_flg_d;
            skid_res_q  <= skid_res_d;
            skid_flg_q  <= skid_flg_d;
            out_valid_q <= (state_d != ST_EMPTY);
            in_ready_q  <= (state_d != ST_FULL);
            fflags_q    <= fflags_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = head_res_q;
    assign out_flags  = head_flg_q;
    assign fflags     = fflags_q;
    assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_fma16_result_stage.sv
// Scoreboard bench for fma16_result_stage: driver queues expected results, a negedge
// monitor pops and compares on every retire.
module tb_fma16_result_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready, in_ready4;
    logic [15:0] in_result;
    logic [3:0]  in_flags;
    logic        out_valid, out_valid4;
    logic        out_ready;
    logic [15:0] out_result, out_result4;
    logic [3:0]  out_flags, out_flags4;
    logic        fflags_we;
    logic [3:0]  fflags_wdata;
    logic [3:0]  fflags, fflags4;
    logic [15:0] retire_cnt;
    logic [3:0]  retire_cnt4;

    int n_vec = 0;
    int n_err = 0;
    logic [19:0] sb[$];

    always #5 clk = ~clk;

    fma16_result_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_flags(in_flags), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags),
        .fflags_we(fflags_we), .fflags_wdata(fflags_wdata), .fflags(fflags),
        .retire_cnt(retire_cnt)
    );

    fma16_result_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
        .in_result(in_result), .in_flags(in_flags), .out_valid(out_valid4),
        .out_ready(out_ready), .out_result(out_result4), .out_flags(out_flags4),
        .fflags_we(fflags_we), .fflags_wdata(fflags_wdata), .fflags(fflags4),
        .retire_cnt(retire_cnt4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every cycle a retire is about to happen, compare against the queue head.
    always @(negedge clk) begin
        if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_output", {16'h0, out_result}, 32'hffffffff);
            end else begin
                logic [19:0] e;
                e = sb.pop_front();
                chk("out_result", {16'h0, out_result}, {16'h0, e[19:4]});
                chk("out_flags", {28'h0, out_flags}, {28'h0, e[3:0]});
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] res, input logic [3:0] flg, input logic exp_acc);
        in_valid  = 1'b1;
        in_result = res;
        in_flags  = flg;
        @(negedge clk);
        chk("in_ready_at_push", {31'h0, in_ready}, {31'h0, exp_acc});
        if (exp_acc) sb.push_back({res, flg});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain;
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
        chk("drain_timeout", sb.size(), 32'd0);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        sb.delete();
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_result = 16'h0; in_flags = 4'b0;
        out_ready = 1'b0; fflags_we = 1'b0; fflags_wdata = 4'b0;
        do_reset();
        chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'd1);
        chk("rst_out_result", {16'h0, out_result}, 32'h0);
        chk("rst_fflags", {28'h0, fflags}, 32'h0);
        chk("rst_cnt", {16'h0, retire_cnt}, 32'h0);

        // 1: single op, one-cycle latency
        out_ready = 1'b1;
        push(16'h3c00, 4'b0001, 1'b1);
        chk("t1_out_valid", {31'h0, out_valid}, 32'd1);
        chk("t1_out_result", {16'h0, out_result}, 32'h3c00);
        drain();
        chk("t1_fflags", {28'h0, fflags}, 32'h1);
        chk("t1_cnt", {16'h0, retire_cnt}, 32'd1);

        // 2: fill skid, drop while full, drain in order
        out_ready = 1'b0;
        push(16'h7e00, 4'b1000, 1'b1);
        push(16'h7bff, 4'b0101, 1'b1);
        chk("t2_in_ready_full", {31'h0, in_ready}, 32'd0);
        push(16'h1234, 4'b1111, 1'b0);
        chk("t2_hold_result", {16'h0, out_result}, 32'h7e00);
        chk("t2_fflags_before", {28'h0, fflags}, 32'h1);
        out_ready = 1'b1;
        drain();
        chk("t2_fflags", {28'h0, fflags}, 32'hd);
        chk("t2_cnt", {16'h0, retire_cnt}, 32'd3);

        // 3: 20 back-to-back ops at full throughput
        for (int i = 0; i < 20; i++) push(16'h0100 + 16'(i), 4'(i), 1'b1);
        drain();
        chk("t3_cnt", {16'h0, retire_cnt}, 32'd23);
        chk("t3_fflags", {28'h0, fflags}, 32'hf);

        // 4: software write coincident with a retire
        out_ready = 1'b0;
        push(16'h0abc, 4'b0010, 1'b1);
        fflags_we = 1'b1; fflags_wdata = 4'b1111;
        tick();
        chk("t4_fflags_w", {28'h0, fflags}, 32'hf);
        fflags_wdata = 4'b0000;
        out_ready = 1'b1;
        tick();
        fflags_we = 1'b0;
        chk("t4_fflags", {28'h0, fflags}, 32'h2);
        chk("t4_cnt", {16'h0, retire_cnt}, 32'd24);

        // 5: reset while full
        out_ready = 1'b0;
        push(16'h1111, 4'b0001, 1'b1);
        push(16'h2222, 4'b0010, 1'b1);
        chk("t5_full", {31'h0, in_ready}, 32'd0);
        do_reset();
        chk("t5_out_valid", {31'h0, out_valid}, 32'd0);
        chk("t5_in_ready", {31'h0, in_ready}, 32'd1);
        chk("t5_out_result", {16'h0, out_result}, 32'h0);
        chk("t5_out_flags", {28'h0, out_flags}, 32'h0);
        chk("t5_fflags", {28'h0, fflags}, 32'h0);
        chk("t5_cnt", {16'h0, retire_cnt}, 32'd0);
        out_ready = 1'b1;
        push(16'h3333, 4'b0100, 1'b1);
        chk("t5_after_valid", {31'h0, out_valid}, 32'd1);
        chk("t5_after_result", {16'h0, out_result}, 32'h3333);
        drain();
        chk("t5_after_fflags", {28'h0, fflags}, 32'h4);
        chk("t5_after_cnt", {16'h0, retire_cnt}, 32'd1);

        // 6: counter wrap on the narrow instance
        do_reset();
        for (int i = 0; i < 17; i++) push(16'h4000 + 16'(i), 4'b0000, 1'b1);
        drain();
        chk("t6_cnt16", {16'h0, retire_cnt}, 32'd17);
        chk("t6_cnt4", {28'h0, retire_cnt4}, 32'd1);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
